// File: rtl/edge_event_counter.sv
// Multi-channel edge-event counter: synchronised inputs, edge detection, saturating
// or wrapping per-channel counters, sticky overflow flags and a registered read port.
module edge_event_counter #(
    parameter int NCHAN       = 4,
    parameter int WIDTH       = 8,
    parameter int EDGE_MODE   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 1,
    localparam int SELW       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [NCHAN-1:0] SIG,
    input  logic             RD_EN,
    input  logic [SELW-1:0]  RD_SEL,
    input  logic             RD_CLR,
    output logic [WIDTH-1:0] XOUT,
    output logic             XVALID,
    output logic [NCHAN-1:0] OVF
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [NCHAN-1:0] sync_p0 [SYNC_STAGES];
    logic [NCHAN-1:0] hist_p1;
    logic [NCHAN-1:0] evt_p2;
    logic [WIDTH-1:0] cnt_p3  [NCHAN];
    logic [NCHAN-1:0] ovf_p3;
    logic [WIDTH-1:0] xout_p4;
    logic             vld_p4;

    logic [NCHAN-1:0] sync_last;
    logic [NCHAN-1:0] evt_raw;
    logic [NCHAN-1:0] sel_hit;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] cnt_nxt [NCHAN];
    logic [NCHAN-1:0] ovf_nxt;

    function automatic logic [NCHAN-1:0] edge_qual(input logic [NCHAN-1:0] cur,
                                                   input logic [NCHAN-1:0] prev);
        case (EDGE_MODE)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] cnt_step(input logic [WIDTH-1:0] c);
        if (c == CNT_MAX)
            return (SATURATE != 0) ? CNT_MAX : '0;
        return c + WIDTH'(1);
    endfunction

    assign sync_last = sync_p0[SYNC_STAGES-1];
    assign evt_raw   = edge_qual(sync_last, hist_p1);

    // Stage 0: input synchroniser chain
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_p0[s] <= '0;
        end else begin
            sync_p0[0] <= SIG;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_p0[s] <= sync_p0[s-1];
        end
    end

    // Stage 1/2: edge history and registered event pulse
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            hist_p1 <= '0;
            evt_p2  <= '0;
        end else begin
            hist_p1 <= sync_last;
            evt_p2  <= evt_raw;
        end
    end

    always_comb begin
        sel_hit = '0;
        rd_data = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (RD_SEL == SELW'(i)) begin
                sel_hit[i] = 1'b1;
                rd_data    = cnt_p3[i];
            end
        end
    end

    // A clear that coincides with an event keeps that event as the first new count.
    always_comb begin
        ovf_nxt = ovf_p3;
        for (int i = 0; i < NCHAN; i++) begin
            cnt_nxt[i] = cnt_p3[i];
            if (RD_EN && RD_CLR && sel_hit[i]) begin
                cnt_nxt[i] = evt_p2[i] ? WIDTH'(1) : '0;
                ovf_nxt[i] = 1'b0;
            end else if (evt_p2[i]) begin
                cnt_nxt[i] = cnt_step(cnt_p3[i]);
                if (cnt_p3[i] == CNT_MAX)
                    ovf_nxt[i] = 1'b1;
            end
        end
    end

    // Stage 3: counters and overflow flags
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < NCHAN; i++)
                cnt_p3[i] <= '0;
            ovf_p3 <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++)
                cnt_p3[i] <= cnt_nxt[i];
            ovf_p3 <= ovf_nxt;
        end
    end

    // Stage 4: registered read port, sampling counts before this edge's update
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            xout_p4 <= '0;
            vld_p4  <= 1'b0;
        end else begin
            vld_p4 <= RD_EN;
            if (RD_EN)
                xout_p4 <= rd_data;
        end
    end

    assign XOUT   = xout_p4;
    assign XVALID = vld_p4;
    assign OVF    = ovf_p3;

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench for edge_event_counter: several parameterisations share one stimulus
// stream so edge modes, widths, wrap/saturate and channel counts are checked together.
module tb_edge_event_counter;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] SIG = '0;
    logic       RD_EN = 1'b0;
    logic [1:0] RD_SEL = '0;
    logic       RD_CLR = 1'b0;

    logic [7:0] xout0, xout1, xout2, xout5;
    logic [3:0] xout3, xout4;
    logic       xv0, xv1, xv2, xv3, xv4, xv5;
    logic [3:0] ovf0, ovf1, ovf2, ovf3, ovf4;
    logic [2:0] ovf5;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    edge_event_counter #(.NCHAN(4), .WIDTH(8), .EDGE_MODE(0), .SYNC_STAGES(2), .SATURATE(1)) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .SIG(SIG), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
        .RD_CLR(RD_CLR), .XOUT(xout0), .XVALID(xv0), .OVF(ovf0));
    edge_event_counter #(.NCHAN(4), .WIDTH(8), .EDGE_MODE(1), .SYNC_STAGES(2), .SATURATE(1)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .SIG(SIG), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
        .RD_CLR(RD_CLR), .XOUT(xout1), .XVALID(xv1), .OVF(ovf1));
    edge_event_counter #(.NCHAN(4), .WIDTH(8), .EDGE_MODE(2), .SYNC_STAGES(2), .SATURATE(1)) u2 (
        .CLK(CLK), .RESET_N(RESET_N), .SIG(SIG), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
        .RD_CLR(RD_CLR), .XOUT(xout2), .XVALID(xv2), .OVF(ovf2));
    edge_event_counter #(.NCHAN(4), .WIDTH(4), .EDGE_MODE(0), .SYNC_STAGES(2), .SATURATE(1)) u3 (
        .CLK(CLK), .RESET_N(RESET_N), .SIG(SIG), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
        .RD_CLR(RD_CLR), .XOUT(xout3), .XVALID(xv3), .OVF(ovf3));
    edge_event_counter #(.NCHAN(4), .WIDTH(4), .EDGE_MODE(0), .SYNC_STAGES(2), .SATURATE(0)) u4 (
        .CLK(CLK), .RESET_N(RESET_N), .SIG(SIG), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
        .RD_CLR(RD_CLR), .XOUT(xout4), .XVALID(xv4), .OVF(ovf4));
    edge_event_counter #(.NCHAN(3), .WIDTH(8), .EDGE_MODE(0), .SYNC_STAGES(2), .SATURATE(1)) u5 (
        .CLK(CLK), .RESET_N(RESET_N), .SIG(SIG[2:0]), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
        .RD_CLR(RD_CLR), .XOUT(xout5), .XVALID(xv5), .OVF(ovf5));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] sel, input logic clr);
        RD_EN  = 1'b1;
        RD_SEL = sel;
        RD_CLR = clr;
        tick();
        RD_EN  = 1'b0;
        RD_CLR = 1'b0;
    endtask

    task automatic pulses(input int ch, input int n);
        for (int p = 0; p < n; p++) begin
            SIG[ch] = 1'b1;
            tick();
            tick();
            SIG[ch] = 1'b0;
            tick();
            tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        // Reset with SIG toggling and a read strobe present
        RESET_N = 1'b0;
        RD_EN   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            SIG = ~SIG;
            tick();
        end
        chk("rst_xout", xout0, 0);
        chk("rst_xvalid", xv0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_ovf_w4", ovf4, 0);
        RESET_N = 1'b1;
        SIG     = '0;
        RD_EN   = 1'b0;
        tick();
        rd(2'd0, 1'b0);
        chk("rd0_after_rst_xout", xout0, 0);
        chk("rd0_after_rst_xvalid", xv0, 1);
        tick();
        chk("xvalid_single_cycle", xv0, 0);

        // Latency: rising edge on ch1 sampled at edge k lands in the counter at k+3
        SIG[1] = 1'b1;
        tick();
        tick();
        tick();
        RD_EN  = 1'b1;
        RD_SEL = 2'd1;
        tick();
        chk("lat_k3_xout", xout0, 0);
        chk("lat_k3_xvalid", xv0, 1);
        tick();
        chk("lat_k4_xout", xout0, 1);
        chk("lat_k4_mode1", xout1, 0);
        chk("lat_k4_mode2", xout2, 1);
        RD_EN  = 1'b0;
        SIG[1] = 1'b0;
        repeat (5) tick();
        rd(2'd1, 1'b0);
        chk("fall_mode1", xout1, 1);
        chk("fall_mode2", xout2, 2);
        chk("fall_mode0", xout0, 1);

        // Edge modes: five full pulses on ch2
        pulses(2, 5);
        rd(2'd2, 1'b0);
        chk("mode0_ch2", xout0, 5);
        chk("mode1_ch2", xout1, 5);
        chk("mode2_ch2", xout2, 10);

        // Overflow: 17 rising edges on ch0
        pulses(0, 17);
        rd(2'd0, 1'b0);
        chk("w8_ch0_cnt", xout0, 17);
        chk("w8_ch0_ovf", ovf0[0], 0);
        chk("w4sat_ch0_cnt", xout3, 15);
        chk("w4sat_ch0_ovf", ovf3[0], 1);
        chk("w4wrap_ch0_cnt", xout4, 1);
        chk("w4wrap_ch0_ovf", ovf4[0], 1);
        chk("n3_ch0_cnt", xout5, 17);

        // Bring ch3 to count 7 with overflow set on the wrapping 4-bit counter
        pulses(3, 23);
        rd(2'd3, 1'b0);
        chk("w4wrap_ch3_pre", xout4, 7);
        chk("w4wrap_ch3_ovf_pre", ovf4[3], 1);
        chk("w8_ch3_pre", xout0, 23);

        // Clear-on-read in the same cycle as a detected edge on ch3
        SIG[3] = 1'b1;
        tick();
        tick();
        tick();
        RD_EN  = 1'b1;
        RD_SEL = 2'd3;
        RD_CLR = 1'b1;
        tick();
        RD_EN  = 1'b0;
        RD_CLR = 1'b0;
        chk("coll_xout_w4", xout4, 7);
        chk("coll_xout_w8", xout0, 23);
        chk("coll_ovf3_cleared", ovf4[3], 0);
        chk("coll_n3_oor_xout", xout5, 0);
        chk("coll_n3_oor_xvalid", xv5, 1);
        SIG[3] = 1'b0;
        repeat (5) tick();
        rd(2'd3, 1'b0);
        chk("post_clr_ch3_w4", xout4, 1);
        chk("post_clr_ch3_w8", xout0, 1);
        chk("post_clr_ovf_w4", ovf4, 4'b0001);
        rd(2'd0, 1'b0);
        chk("other_ch0_w4", xout4, 1);
        chk("other_ch0_w8", xout0, 17);
        chk("other_ch0_n3", xout5, 17);

        // Out-of-range select on the three-channel instance
        rd(2'd3, 1'b0);
        chk("oor_xout", xout5, 0);
        chk("oor_xvalid", xv5, 1);
        rd(2'd2, 1'b0);
        chk("oor_ch2_kept", xout5, 5);
        chk("oor_ovf_kept", ovf5, 0);

        // Reset during a read, with ch1 held high across reset
        SIG[1]  = 1'b1;
        RD_EN   = 1'b1;
        RD_SEL  = 2'd2;
        RESET_N = 1'b0;
        tick();
        chk("rst_read_xvalid", xv0, 0);
        chk("rst_read_xout", xout0, 0);
        tick();
        RESET_N = 1'b1;
        RD_EN   = 1'b0;
        repeat (5) tick();
        rd(2'd1, 1'b0);
        chk("held_high_rise", xout0, 1);
        chk("held_high_mode1", xout1, 0);
        rd(2'd2, 1'b0);
        chk("rst_cleared_ch2", xout0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
